// File: rtl/lcd_scan.sv
// rtl/lcd_scan.sv - PicoBlaze-controlled LCD timing generator with a one-pixel output pipeline
module lcd_scan #(
  parameter int BASE  = 2,
  parameter int DIV   = 4,
  parameter int H_ACT = 480,
  parameter int H_FP  = 20,
  parameter int H_SW  = 10,
  parameter int H_BP  = 30,
  parameter int V_ACT = 234,
  parameter int V_FP  = 4,
  parameter int V_SW  = 2,
  parameter int V_BP  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic [8:0] HDATA,
  output logic [8:0] VDATA,
  output logic       Stroka,
  input  logic [5:0] ODATA,
  output logic       LCD_CLK,
  output logic       LCD_HS,
  output logic       LCD_VS,
  output logic       LCD_DE,
  output logic [5:0] LCD_RGB
);

  localparam logic [3:0]  DIV_LAST = 4'(DIV - 1);
  localparam logic [3:0]  DIV_HALF = 4'(DIV / 2);
  localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
  localparam logic [10:0] H_LAST   = 11'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [10:0] HS_BEG   = 11'(H_ACT + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACT + H_FP + H_SW);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACT);
  localparam logic [10:0] V_LAST   = 11'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam logic [10:0] VS_BEG   = 11'(V_ACT + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACT + V_FP + V_SW);
  localparam logic [7:0]  A_CTRL   = 8'(BASE);
  localparam logic [7:0]  A_FILL   = 8'(BASE + 1);
  localparam logic [7:0]  A_FRM    = 8'(BASE + 2);

  logic [3:0]  div;
  logic [10:0] hcnt, vcnt, h_nxt, v_nxt;
  logic [15:0] frames;
  logic [7:0]  shadow, rd_data;
  logic [5:0]  fill;
  logic        en, freeze, hi_pend;
  logic        pix_en, ctrl_wr, en_eff, freeze_eff, halt;
  logic        h_wrap, v_wrap, act, nxt_act, in_hs, in_vs, vblank;

  // A CTRL write landing on the same CLK as a pix_en steers that pixel directly.
  always_comb begin
    ctrl_wr    = write_strobe && (port_id == A_CTRL);
    en_eff     = ctrl_wr ? out_port[0] : en;
    freeze_eff = ctrl_wr ? out_port[1] : freeze;
    pix_en     = (div == DIV_LAST);
    halt       = freeze_eff && (hcnt == 11'd0) && (vcnt == 11'd0);
    h_wrap     = (hcnt == H_LAST);
    v_wrap     = (vcnt == V_LAST);
    h_nxt      = h_wrap ? 11'd0 : hcnt + 11'd1;
    v_nxt      = h_wrap ? (v_wrap ? 11'd0 : vcnt + 11'd1) : vcnt;
    act        = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    nxt_act    = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    in_hs      = (hcnt >= HS_BEG) && (hcnt < HS_END);
    in_vs      = (vcnt >= VS_BEG) && (vcnt < VS_END);
    vblank     = (vcnt >= V_ACT_C);
    rd_data    = 8'h00;
    if (port_id == A_CTRL)
      rd_data = {6'b0, freeze, en};
    else if (port_id == A_FILL)
      rd_data = {vblank, halt, fill};
    else if (port_id == A_FRM)
      rd_data = hi_pend ? shadow : frames[7:0];
  end

  assign LCD_CLK = (div >= DIV_HALF);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div     <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      frames  <= '0;
      HDATA   <= '0;
      VDATA   <= '0;
      Stroka  <= 1'b0;
      LCD_DE  <= 1'b0;
      LCD_HS  <= 1'b1;
      LCD_VS  <= 1'b1;
      LCD_RGB <= '0;
    end else begin
      div <= pix_en ? 4'd0 : div + 4'd1;
      if (pix_en) begin
        if (halt) begin
          LCD_DE  <= 1'b0;
          LCD_HS  <= 1'b1;
          LCD_VS  <= 1'b1;
          LCD_RGB <= fill;
        end else begin
          hcnt    <= h_nxt;
          vcnt    <= v_nxt;
          HDATA   <= nxt_act ? h_nxt[8:0] : 9'd0;
          VDATA   <= (v_nxt < V_ACT_C) ? v_nxt[8:0] : 9'd0;
          Stroka  <= (h_nxt == H_ACT_C);
          // Outputs describe the pixel that is ending, aligning them with LCD_RGB.
          LCD_DE  <= act && en_eff;
          LCD_HS  <= !in_hs;
          LCD_VS  <= !in_vs;
          LCD_RGB <= (act && en_eff) ? ODATA : fill;
          if (h_wrap && v_wrap)
            frames <= frames + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en      <= 1'b1;
      freeze  <= 1'b0;
      fill    <= '0;
      shadow  <= '0;
      hi_pend <= 1'b0;
      in_port <= '0;
    end else begin
      in_port <= rd_data;
      if (ctrl_wr) begin
        en     <= out_port[0];
        freeze <= out_port[1];
      end
      if (write_strobe && (port_id == A_FILL))
        fill <= out_port[5:0];
      // Alternate reads of the frame port return low byte, then the latched high byte.
      if (read_strobe && (port_id == A_FRM)) begin
        if (!hi_pend) begin
          shadow  <= frames[15:8];
          hi_pend <= 1'b1;
        end else begin
          hi_pend <= 1'b0;
        end
      end
    end
  end

endmodule
